// File: rtl/unstriping_pkg.sv
// Shared types for the two-lane un-striping receive path.
package unstriping_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FLUSH = 2'b10
  } state_t;

  typedef logic lane_idx_t;

endpackage

// File: rtl/lane_fifo.sv
// Per-lane word buffer. Fullness is judged on the pre-edge count, so a pop
// on the same edge never makes room for a write.
module lane_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_acc, rd_acc;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign wr_acc = wr_en && !full && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/lane_deskew_scheduler.sv
// Two-lane deskew: buffers each lane and re-interleaves lane 0 / lane 1 words,
// flushing on excessive skew.
module lane_deskew_scheduler
  import unstriping_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = 4,
  parameter int SKEW_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_0,
  input  logic [WIDTH-1:0] lane_0,
  input  logic             valid_1,
  input  logic [WIDTH-1:0] lane_1,
  output logic             ready_0,
  output logic             ready_1,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active,
  output logic             skew_error,
  output logic             overflow
);

  localparam int CW  = $clog2(SKEW_MAX) + 1;
  localparam int FCW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  STALL_LIM = CW'(SKEW_MAX - 1);
  localparam logic [FCW-1:0] DEPTH_CNT = FCW'(DEPTH);

  state_t           state_q, state_d;
  lane_idx_t        turn_q, turn_d;
  logic [CW-1:0]    stall_q, stall_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             vout_q, vout_d;
  logic             skew_q, skew_d;
  logic             ovf_q, ovf_d;

  logic             pop0, pop1, flush;
  logic [WIDTH-1:0] rd0, rd1;
  logic [FCW-1:0]   cnt0, cnt1;
  logic             full0, full1, empty0, empty1;

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .reset(reset), .wr_en(valid_0), .wr_data(lane_0),
    .rd_en(pop0), .rd_data(rd0), .flush(flush),
    .count(cnt0), .full(full0), .empty(empty0)
  );

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .reset(reset), .wr_en(valid_1), .wr_data(lane_1),
    .rd_en(pop1), .rd_data(rd1), .flush(flush),
    .count(cnt1), .full(full1), .empty(empty1)
  );

  assign flush      = (state_q == FLUSH);
  assign ready_0    = (cnt0 < DEPTH_CNT);
  assign ready_1    = (cnt1 < DEPTH_CNT);
  assign data_out   = data_q;
  assign valid_out  = vout_q;
  assign active     = (state_q == RUN);
  assign skew_error = skew_q;
  assign overflow   = ovf_q;

  always_comb begin
    state_d = state_q;
    turn_d  = turn_q;
    stall_d = stall_q;
    data_d  = data_q;
    vout_d  = 1'b0;
    skew_d  = skew_q;
    pop0    = 1'b0;
    pop1    = 1'b0;
    // Writes landing in the flush cycle are discarded, not counted as drops.
    ovf_d   = ovf_q | (!flush && ((valid_0 && full0) || (valid_1 && full1)));

    case (state_q)
      IDLE: begin
        if (!empty0 && !empty1) begin
          pop0    = 1'b1;
          data_d  = rd0;
          vout_d  = 1'b1;
          turn_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (turn_q ? !empty1 : !empty0) begin
          pop0    = !turn_q;
          pop1    = turn_q;
          data_d  = turn_q ? rd1 : rd0;
          vout_d  = 1'b1;
          turn_d  = ~turn_q;
          stall_d = '0;
        end else if (!turn_q && empty0 && empty1) begin
          state_d = IDLE;
          stall_d = '0;
        end else if (stall_q == STALL_LIM) begin
          // SKEW_MAX-1 stalls already tolerated; this one is too many.
          skew_d  = 1'b1;
          stall_d = '0;
          state_d = FLUSH;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      FLUSH: begin
        turn_d  = 1'b0;
        stall_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      turn_q  <= 1'b0;
      stall_q <= '0;
      data_q  <= '0;
      vout_q  <= 1'b0;
      skew_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      turn_q  <= turn_d;
      stall_q <= stall_d;
      data_q  <= data_d;
      vout_q  <= vout_d;
      skew_q  <= skew_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_lane_deskew_scheduler.sv
// Directed bench for lane_deskew_scheduler: vector table plus corner-case
// sequences and a cycle model for the full-rate stress run.
module tb_lane_deskew_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_0, valid_1;
  logic [31:0] lane_0, lane_1;
  logic        ready_0, ready_1;
  logic [31:0] data_out;
  logic        valid_out, active, skew_error, overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lane_deskew_scheduler #(.WIDTH(32), .DEPTH(4), .SKEW_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .valid_0(valid_0), .lane_0(lane_0),
    .valid_1(valid_1), .lane_1(lane_1),
    .ready_0(ready_0), .ready_1(ready_1),
    .data_out(data_out), .valid_out(valid_out), .active(active),
    .skew_error(skew_error), .overflow(overflow)
  );

  typedef struct {
    logic        v0;
    logic [31:0] d0;
    logic        v1;
    logic [31:0] d1;
    logic        vo;
    logic [31:0] dout;
    logic        act;
    logic        r0;
    logic        r1;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act_v, exp_v);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic cyc(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
    @(negedge clk);
    valid_0 = v0; lane_0 = d0; valid_1 = v1; lane_1 = d1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid_0 = 0; valid_1 = 0; lane_0 = '0; lane_1 = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference model for the stress run.
  logic [31:0] mq0 [$];
  logic [31:0] mq1 [$];
  int          ms, mt, mstall;
  logic [31:0] mdo;
  logic        mvo, mskew, movf;

  task automatic model_reset();
    mq0.delete(); mq1.delete();
    ms = 0; mt = 0; mstall = 0; mdo = '0; mvo = 0; mskew = 0; movf = 0;
  endtask

  task automatic model_step(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
    int n0, n1;
    logic fl;
    n0 = mq0.size(); n1 = mq1.size();
    mvo = 0; fl = 0;
    case (ms)
      0: if (n0 > 0 && n1 > 0) begin
           mdo = mq0.pop_front(); mvo = 1; mt = 1; ms = 1;
         end
      1: if ((mt == 1 && n1 > 0) || (mt == 0 && n0 > 0)) begin
           if (mt == 1) mdo = mq1.pop_front(); else mdo = mq0.pop_front();
           mvo = 1; mt = 1 - mt; mstall = 0;
         end else if (mt == 0 && n0 == 0 && n1 == 0) begin
           ms = 0; mstall = 0;
         end else if (mstall == 7) begin
           mskew = 1; mstall = 0; ms = 2;
         end else begin
           mstall++;
         end
      default: begin fl = 1; mt = 0; ms = 0; mstall = 0; end
    endcase
    if (fl) begin
      mq0.delete(); mq1.delete();
    end else begin
      if (v0) begin if (n0 < 4) mq0.push_back(d0); else movf = 1; end
      if (v1) begin if (n1 < 4) mq1.push_back(d1); else movf = 1; end
    end
  endtask

  logic [31:0] ovf_exp [8];

  initial begin
    // Balanced aligned burst, one word per lane every 2 cycles.
    vecs[0]  = '{1, 32'hA000_0000, 1, 32'hB000_0000, 0, 32'h0,         0, 1, 1};
    vecs[1]  = '{0, 32'h0,         0, 32'h0,         1, 32'hA000_0000, 1, 1, 1};
    vecs[2]  = '{1, 32'hA000_0001, 1, 32'hB000_0001, 1, 32'hB000_0000, 1, 1, 1};
    vecs[3]  = '{0, 32'h0,         0, 32'h0,         1, 32'hA000_0001, 1, 1, 1};
    vecs[4]  = '{1, 32'hA000_0002, 1, 32'hB000_0002, 1, 32'hB000_0001, 1, 1, 1};
    vecs[5]  = '{0, 32'h0,         0, 32'h0,         1, 32'hA000_0002, 1, 1, 1};
    vecs[6]  = '{0, 32'h0,         0, 32'h0,         1, 32'hB000_0002, 1, 1, 1};
    vecs[7]  = '{0, 32'h0,         0, 32'h0,         0, 32'hB000_0002, 0, 1, 1};
    // Lane 1 lagging lane 0 by 3 cycles.
    vecs[8]  = '{1, 32'hAAAA_0001, 0, 32'h0,         0, 32'hB000_0002, 0, 1, 1};
    vecs[9]  = '{0, 32'h0,         0, 32'h0,         0, 32'hB000_0002, 0, 1, 1};
    vecs[10] = '{1, 32'hAAAA_0002, 0, 32'h0,         0, 32'hB000_0002, 0, 1, 1};
    vecs[11] = '{0, 32'h0,         1, 32'hBBBB_0001, 0, 32'hB000_0002, 0, 1, 1};
    vecs[12] = '{1, 32'hAAAA_0003, 0, 32'h0,         1, 32'hAAAA_0001, 1, 1, 1};
    vecs[13] = '{0, 32'h0,         1, 32'hBBBB_0002, 1, 32'hBBBB_0001, 1, 1, 1};
    vecs[14] = '{0, 32'h0,         0, 32'h0,         1, 32'hAAAA_0002, 1, 1, 1};
    vecs[15] = '{0, 32'h0,         1, 32'hBBBB_0003, 1, 32'hBBBB_0002, 1, 1, 1};
    vecs[16] = '{0, 32'h0,         0, 32'h0,         1, 32'hAAAA_0003, 1, 1, 1};
    vecs[17] = '{0, 32'h0,         0, 32'h0,         1, 32'hBBBB_0003, 1, 1, 1};
    vecs[18] = '{0, 32'h0,         0, 32'h0,         0, 32'hBBBB_0003, 0, 1, 1};

    valid_0 = 0; valid_1 = 0; lane_0 = '0; lane_1 = '0;
    reset = 1'b1;
    #12;
    chk("rst_data_out",  data_out,   32'h0);
    chk("rst_valid_out", valid_out,  0);
    chk("rst_active",    active,     0);
    chk("rst_ready_0",   ready_0,    1);
    chk("rst_ready_1",   ready_1,    1);
    chk("rst_skew",      skew_error, 0);
    chk("rst_ovf",       overflow,   0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      cyc(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1);
      chk($sformatf("vec%0d_valid_out", i), valid_out, vecs[i].vo);
      chk($sformatf("vec%0d_data_out", i),  data_out,  vecs[i].dout);
      chk($sformatf("vec%0d_active", i),    active,    vecs[i].act);
      chk($sformatf("vec%0d_ready_0", i),   ready_0,   vecs[i].r0);
      chk($sformatf("vec%0d_ready_1", i),   ready_1,   vecs[i].r1);
    end
    chk("vec_skew_error", skew_error, 0);
    chk("vec_overflow",   overflow,   0);

    // Skew error: lane 1 stops after one word; stale lane 0 word must be flushed.
    do_reset();
    cyc(1, 32'hA1A1_0000, 1, 32'hB1B1_0000);
    cyc(1, 32'hA1A1_0001, 0, 0);
    chk("skw_out0", data_out, 32'hA1A1_0000);
    cyc(0, 0, 0, 0);
    chk("skw_out1", data_out, 32'hB1B1_0000);
    cyc(0, 0, 0, 0);
    chk("skw_out2", data_out, 32'hA1A1_0001);
    for (int k = 4; k <= 10; k++) cyc(k == 6, 32'hA1A1_0002, 0, 0);
    chk("skw_7stall_err",    skew_error, 0);
    chk("skw_7stall_active", active,     1);
    chk("skw_7stall_valid",  valid_out,  0);
    cyc(0, 0, 0, 0);
    chk("skw_8stall_err",    skew_error, 1);
    chk("skw_8stall_active", active,     0);
    cyc(0, 0, 1, 32'hDEAD_BEEF);
    chk("skw_flush_valid",   valid_out,  0);
    chk("skw_flush_hold",    data_out,   32'hA1A1_0001);
    cyc(1, 32'hC0C0_0000, 1, 32'hD0D0_0000);
    chk("skw_post_idle",     valid_out,  0);
    cyc(0, 0, 0, 0);
    chk("skw_post_out0",     data_out,   32'hC0C0_0000);
    cyc(0, 0, 0, 0);
    chk("skw_post_out1",     data_out,   32'hD0D0_0000);
    cyc(0, 0, 0, 0);
    chk("skw_post_active",   active,     0);
    chk("skw_sticky",        skew_error, 1);

    // Overflow: five lane 0 writes into a 4-deep buffer, fifth dropped.
    do_reset();
    for (int k = 1; k <= 4; k++) cyc(1, 32'h5700_0000 + k, 0, 0);
    chk("ovf_ready0_low", ready_0,  0);
    chk("ovf_before",     overflow, 0);
    cyc(1, 32'h5700_0005, 0, 0);
    chk("ovf_set",        overflow, 1);
    ovf_exp = '{32'h5700_0001, 32'h6600_0001, 32'h5700_0002, 32'h6600_0002,
                32'h5700_0003, 32'h6600_0003, 32'h5700_0004, 32'h6600_0004};
    cyc(0, 0, 1, 32'h6600_0001);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, k < 3, 32'h6600_0002 + k);
      chk($sformatf("ovf_out%0d_valid", k), valid_out, 1);
      chk($sformatf("ovf_out%0d_data", k),  data_out,  ovf_exp[k]);
    end
    cyc(0, 0, 0, 0);
    chk("ovf_end_active", active,   0);
    chk("ovf_sticky",     overflow, 1);

    // Reset asserted mid-burst with words still buffered.
    cyc(1, 32'hE000_0000, 1, 32'hF000_0000);
    cyc(1, 32'hE000_0001, 1, 32'hF000_0001);
    chk("mid_active", active, 1);
    @(negedge clk);
    valid_0 = 0; valid_1 = 0;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid",  valid_out,  0);
    chk("mid_rst_data",   data_out,   32'h0);
    chk("mid_rst_active", active,     0);
    chk("mid_rst_ovf",    overflow,   0);
    chk("mid_rst_skew",   skew_error, 0);
    chk("mid_rst_r0",     ready_0,    1);
    chk("mid_rst_r1",     ready_1,    1);
    @(negedge clk);
    reset = 1'b0;
    cyc(1, 32'h1234_0000, 1, 32'h5678_0000);
    chk("mid_fresh_idle", valid_out, 0);
    cyc(0, 0, 0, 0);
    chk("mid_fresh_out0", data_out, 32'h1234_0000);
    cyc(0, 0, 0, 0);
    chk("mid_fresh_out1", data_out, 32'h5678_0000);
    cyc(0, 0, 0, 0);
    chk("mid_fresh_end",  active,   0);
    chk("mid_fresh_vo",   valid_out, 0);

    // Full-rate stress against the cycle model.
    do_reset();
    model_reset();
    for (int c = 0; c < 50; c++) begin
      logic        w;
      logic [31:0] a, b;
      w = (c < 20);
      a = 32'hC000_0000 + c;
      b = 32'hD000_0000 + c;
      model_step(w, a, w, b);
      cyc(w, a, w, b);
      chk($sformatf("str%0d_valid", c), valid_out,  mvo);
      chk($sformatf("str%0d_data", c),  data_out,   mdo);
      chk($sformatf("str%0d_active", c), active,    ms == 1);
      chk($sformatf("str%0d_r0", c),    ready_0,    mq0.size() < 4);
      chk($sformatf("str%0d_r1", c),    ready_1,    mq1.size() < 4);
      chk($sformatf("str%0d_ovf", c),   overflow,   movf);
      chk($sformatf("str%0d_skew", c),  skew_error, mskew);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
